// File: rtl/compensador_pkg.sv
// Shared FSM encoding and fixed-point helpers for the first-order IIR compensator.
package compensador_pkg;

  typedef enum logic [2:0] {IDLE, MUL_B0, MUL_B1, MUL_A1, ROUND} state_e;

  // Two guard bits keep the sum of three full-width products from overflowing.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 2;
  endfunction

  // Round-half-up via bias then arithmetic shift, then saturate to the duty range.
  function automatic longint round_shift_clamp(input longint acc, input int frac,
                                               input longint u_min, input longint u_max);
    longint r;
    r = (acc + (longint'(1) <<< (frac - 1))) >>> frac;
    if (r > u_max)      r = u_max;
    else if (r < u_min) r = u_min;
    return r;
  endfunction

endpackage

// File: rtl/comp_mac_fx.sv
// Signed coefficient x data multiply with a registered accumulator; clr_i restarts the sum.
module comp_mac_fx #(
  parameter int DW = 16,
  parameter int CW = 18,
  parameter int AW = DW + CW + 2
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [DW-1:0] data_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = $signed({{DW{coef_i[CW-1]}}, coef_i}) * $signed({{CW{data_i[DW-1]}}, data_i});
    acc_d = clr_i ? AW'(prod) : acc_q + AW'(prod);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/compensador_iir1_fx.sv
// Fixed-point first-order compensator u = a1*u' + b0*e + b1*e', one shared MAC, clamped duty out.
module compensador_iir1_fx
  import compensador_pkg::*;
#(
  parameter int DW     = 16,
  parameter int CW     = 18,
  parameter int FRAC   = 14,
  parameter int OW     = 12,
  parameter int U_MAX  = 4095,
  parameter int U_MIN  = 0,
  parameter int B0_DEF = 16384,
  parameter int B1_DEF = 0,
  parameter int A1_DEF = 0
) (
  input  logic                 clk_50,
  input  logic                 rst,
  input  logic                 fs_tick,
  input  logic signed [DW-1:0] e_i,
  input  logic                 coef_ld,
  input  logic signed [CW-1:0] b0_i,
  input  logic signed [CW-1:0] b1_i,
  input  logic signed [CW-1:0] a1_i,
  input  logic                 hold_i,
  input  logic                 clr_ovr,
  output logic signed [DW-1:0] u_o,
  output logic [OW-1:0]        d_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int AW = acc_width(DW, CW);

  state_e state_q, state_d;

  logic signed [DW-1:0] e_cur_q, e_prev_q, u_q, u_rnd;
  logic signed [CW-1:0] b0_q, b1_q, a1_q;
  logic signed [CW-1:0] b0_sh_q, b1_sh_q, a1_sh_q;
  logic                 valid_q, ovr_q;

  logic                 start, ovr_set;
  logic                 mac_en, mac_clr;
  logic signed [CW-1:0] mac_coef;
  logic signed [DW-1:0] mac_data;
  logic signed [AW-1:0] acc;

  assign start   = (state_q == IDLE) && fs_tick && !hold_i;
  assign ovr_set = (state_q != IDLE) && fs_tick;

  always_comb begin
    state_d  = state_q;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    mac_coef = b0_q;
    mac_data = e_cur_q;
    case (state_q)
      IDLE:   if (start) state_d = MUL_B0;
      MUL_B0: begin
        mac_en  = 1'b1;
        mac_clr = 1'b1;
        state_d = MUL_B1;
      end
      MUL_B1: begin
        mac_en   = 1'b1;
        mac_coef = b1_q;
        mac_data = e_prev_q;
        state_d  = MUL_A1;
      end
      MUL_A1: begin
        mac_en   = 1'b1;
        mac_coef = a1_q;
        mac_data = u_q;
        state_d  = ROUND;
      end
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  comp_mac_fx #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .gclk   (clk_50),
    .grst_n (rst),
    .en_i   (mac_en),
    .clr_i  (mac_clr),
    .coef_i (mac_coef),
    .data_i (mac_data),
    .acc_o  (acc)
  );

  assign u_rnd = DW'(round_shift_clamp(longint'(acc), FRAC, longint'(U_MIN), longint'(U_MAX)));

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      e_cur_q  <= '0;
      e_prev_q <= '0;
      u_q      <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      b0_q     <= CW'(B0_DEF);
      b1_q     <= CW'(B1_DEF);
      a1_q     <= CW'(A1_DEF);
      b0_sh_q  <= CW'(B0_DEF);
      b1_sh_q  <= CW'(B1_DEF);
      a1_sh_q  <= CW'(A1_DEF);
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == ROUND);
      if (coef_ld) begin
        b0_sh_q <= b0_i;
        b1_sh_q <= b1_i;
        a1_sh_q <= a1_i;
      end
      // Active set samples the shadow before a coincident coef_ld lands.
      if (start) begin
        e_cur_q <= e_i;
        b0_q    <= b0_sh_q;
        b1_q    <= b1_sh_q;
        a1_q    <= a1_sh_q;
      end
      // Storing the clamped value as loop state is what prevents windup.
      if (state_q == ROUND) begin
        u_q      <= u_rnd;
        e_prev_q <= e_cur_q;
      end
      if (ovr_set)      ovr_q <= 1'b1;
      else if (clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign u_o       = u_q;
  assign d_o       = u_q[OW-1:0];
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_compensador_iir1_fx.sv
// Self-checking bench: directed scenarios plus randomized samples against a difference-equation model.
module tb_compensador_iir1_fx;

  localparam int DW = 16, CW = 18, OW = 12;
  localparam longint ONE = 16384, UMAX = 4095, UMIN = 0;

  logic                 clk_50 = 1'b0, rst = 1'b1;
  logic                 fs_tick = 1'b0, coef_ld = 1'b0, hold_i = 1'b0, clr_ovr = 1'b0;
  logic signed [DW-1:0] e_i = '0;
  logic signed [CW-1:0] b0_i = '0, b1_i = '0, a1_i = '0;
  logic signed [DW-1:0] u_o;
  logic [OW-1:0]        d_o;
  logic                 valid_o, busy_o, overrun_o;

  int n_cmp = 0, n_bad = 0;
  longint m_b0, m_b1, m_a1, m_up, m_ep;

  compensador_iir1_fx dut (
    .clk_50(clk_50), .rst(rst), .fs_tick(fs_tick), .e_i(e_i), .coef_ld(coef_ld),
    .b0_i(b0_i), .b1_i(b1_i), .a1_i(a1_i), .hold_i(hold_i), .clr_ovr(clr_ovr),
    .u_o(u_o), .d_o(d_o), .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // Coefficients used at a tick are whatever was loaded before that tick.
  function automatic longint mdl(input longint e);
    longint r;
    r = floor_div(m_b0 * e + m_b1 * m_ep + m_a1 * m_up + ONE / 2, ONE);
    if (r > UMAX) r = UMAX;
    if (r < UMIN) r = UMIN;
    m_up = r;
    m_ep = e;
    return r;
  endfunction

  task automatic mdl_rst();
    m_b0 = ONE; m_b1 = 0; m_a1 = 0; m_up = 0; m_ep = 0;
  endtask

  task automatic do_rst();
    @(negedge clk_50); rst = 1'b0;
    @(negedge clk_50); @(negedge clk_50); rst = 1'b1;
    mdl_rst();
  endtask

  task automatic ld(input longint nb0, input longint nb1, input longint na1);
    @(negedge clk_50);
    coef_ld = 1'b1; b0_i = CW'(nb0); b1_i = CW'(nb1); a1_i = CW'(na1);
    @(negedge clk_50);
    coef_ld = 1'b0;
    m_b0 = nb0; m_b1 = nb1; m_a1 = na1;
  endtask

  // One sample; returns the model's expected output (or the held value if ignored).
  task automatic smp(input longint e, input bit hold, input bit ldc,
                     input longint nb0, input longint nb1, input longint na1,
                     output longint exp);
    int lat, nv;
    @(negedge clk_50);
    fs_tick = 1'b1; e_i = DW'(e); hold_i = hold; coef_ld = ldc;
    b0_i = CW'(nb0); b1_i = CW'(nb1); a1_i = CW'(na1);
    @(negedge clk_50);
    fs_tick = 1'b0; hold_i = 1'b0; coef_ld = 1'b0;
    exp = m_up;
    if (!hold) exp = mdl(e);
    if (ldc) begin m_b0 = nb0; m_b1 = nb1; m_a1 = na1; end
    lat = -1; nv = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_50);
      if (valid_o) begin nv++; if (lat < 0) lat = i; end
    end
    if (!hold) begin
      chk("latency", lat, 4);
      chk("nvalid", nv, 1);
    end else chk("hold_nvalid", nv, 0);
    chk("u_o", u_o, exp);
    chk("d_o", d_o, exp);
  endtask

  task automatic smp_e(input longint e, output longint exp);
    smp(e, 1'b0, 1'b0, 0, 0, 0, exp);
  endtask

  initial begin
    longint exp, exp1;
    int nv;
    mdl_rst();
    #5 rst = 1'b0;
    #20;
    chk("rst_u", u_o, 0);
    chk("rst_d", d_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovr", overrun_o, 0);
    @(negedge clk_50); rst = 1'b1;

    smp_e(100, exp);
    chk("pass_100", u_o, 100);

    do_rst();
    ld(ONE, 0, ONE);
    for (int k = 1; k <= 3; k++) begin
      smp_e(10, exp);
      chk("integ", u_o, 10 * k);
    end

    do_rst();
    ld(ONE, 0, ONE);
    for (int k = 1; k <= 6; k++) begin
      smp_e(1000, exp);
      chk("sat", u_o, (k <= 4) ? 1000 * k : 4095);
    end
    smp_e(1000, exp);
    chk("sat_held", u_o, 4095);
    smp_e(-1000, exp);
    chk("antiwindup", u_o, 3095);

    ld(8192, 0, 0);
    smp_e(5, exp);
    chk("round_pos", u_o, 3);
    smp_e(-5, exp);
    chk("round_neg_d", d_o, 0);

    smp(77, 1'b1, 1'b0, 0, 0, 0, exp);
    chk("hold_noovr", overrun_o, 0);

    // Second tick two cycles after the first, with a coefficient load while busy.
    ld(ONE, 0, 0);
    @(negedge clk_50); fs_tick = 1'b1; e_i = 16'sd50;
    @(negedge clk_50); fs_tick = 1'b0;
    exp1 = mdl(50);
    @(negedge clk_50);
    chk("busy_mid", busy_o, 1);
    fs_tick = 1'b1; e_i = 16'sd999;
    coef_ld = 1'b1; b0_i = 18'sd32768; b1_i = '0; a1_i = '0;
    @(negedge clk_50); fs_tick = 1'b0; coef_ld = 1'b0;
    m_b0 = 32768; m_b1 = 0; m_a1 = 0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk_50); if (valid_o) nv++; end
    chk("ovr_nvalid", nv, 1);
    chk("ovr_u_oldb0", u_o, exp1);
    chk("ovr_flag", overrun_o, 1);
    chk("ovr_idle", busy_o, 0);
    smp_e(100, exp);
    chk("newb0_200", u_o, 200);
    chk("ovr_sticky", overrun_o, 1);
    @(negedge clk_50); clr_ovr = 1'b1;
    @(negedge clk_50); clr_ovr = 1'b0;
    chk("ovr_clr", overrun_o, 0);

    // Overrun set coincides with clear: set must win.
    @(negedge clk_50); fs_tick = 1'b1; e_i = 16'sd1;
    @(negedge clk_50); clr_ovr = 1'b1;
    exp1 = mdl(1);
    @(negedge clk_50); fs_tick = 1'b0; clr_ovr = 1'b0;
    chk("ovr_setwins", overrun_o, 1);
    for (int i = 0; i < 6; i++) @(negedge clk_50);
    chk("setwins_u", u_o, exp1);
    @(negedge clk_50); clr_ovr = 1'b1;
    @(negedge clk_50); clr_ovr = 1'b0;

    // Reset while the a1 product is being accumulated.
    ld(ONE, 0, 0);
    @(negedge clk_50); fs_tick = 1'b1; e_i = 16'sd123;
    @(negedge clk_50); fs_tick = 1'b0;
    @(negedge clk_50); @(negedge clk_50);
    #2 rst = 1'b0;
    #1;
    chk("midrst_u", u_o, 0);
    chk("midrst_d", d_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", valid_o, 0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk_50); if (valid_o) nv++; end
    chk("midrst_nvalid", nv, 0);
    rst = 1'b1;
    mdl_rst();
    smp_e(7, exp);
    chk("post_rst_7", u_o, 7);

    for (int k = 0; k < 40; k++) begin
      longint e, nb0, nb1, na1;
      bit h, l;
      e   = longint'($urandom_range(4000, 0)) - 2000;
      nb0 = longint'($urandom_range(40000, 0)) - 20000;
      nb1 = longint'($urandom_range(40000, 0)) - 20000;
      na1 = longint'($urandom_range(32768, 0)) - 16384;
      h   = ($urandom_range(7, 0) == 0);
      l   = ($urandom_range(2, 0) == 0);
      smp(e, h, l, nb0, nb1, na1, exp);
    end
    chk("rand_noovr", overrun_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
